// File: rtl/cmd_arbiter.sv
// Two-source command arbiter: grants UART (priority) or tour commands to the
// command processor, tracks completion, and returns a response byte or timeout.
module cmd_arbiter #(
  parameter logic [23:0] TMO_CYC = 24'hFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_rdy_UART,
  input  logic [15:0] cmd_tour,
  input  logic        cmd_rdy_tour,
  output logic        clr_rdy_tour,
  input  logic        tour_last,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic        send_resp_tour,
  output logic [7:0]  resp,
  output logic        resp_vld,
  output logic        owner_tour,
  output logic        tmo_err
);

  typedef enum logic [1:0] {IDLE, PEND, BUSY} state_t;

  state_t      state_q, state_d;
  logic        idle_hold_q, idle_hold_d;
  logic [15:0] cmd_q, cmd_d;
  logic        cmd_rdy_q, cmd_rdy_d;
  logic        clr_uart_q, clr_uart_d;
  logic        clr_tour_q, clr_tour_d;
  logic        srt_q, srt_d;
  logic [7:0]  resp_q, resp_d;
  logic        resp_vld_q, resp_vld_d;
  logic        owner_q, owner_d;
  logic        tmo_q, tmo_d;
  logic [23:0] wdog_q, wdog_d;

  logic [23:0] wdog_inc;
  logic [7:0]  done_resp;

  assign wdog_inc  = wdog_q + 24'd1;
  // Only a tour move that is not the last one gets the "more to come" byte.
  assign done_resp = (owner_q && !tour_last) ? 8'h5A : 8'hA5;

  always_comb begin
    state_d     = state_q;
    idle_hold_d = idle_hold_q;
    cmd_d       = cmd_q;
    cmd_rdy_d   = cmd_rdy_q;
    clr_uart_d  = 1'b0;
    clr_tour_d  = 1'b0;
    srt_d       = 1'b0;
    resp_d      = resp_q;
    resp_vld_d  = 1'b0;
    owner_d     = owner_q;
    tmo_d       = 1'b0;
    wdog_d      = wdog_q;

    case (state_q)
      IDLE: begin
        // One mandatory idle cycle after each completion before re-granting.
        if (idle_hold_q) begin
          idle_hold_d = 1'b0;
        end else if (cmd_rdy_UART) begin
          cmd_d      = cmd_UART;
          cmd_rdy_d  = 1'b1;
          owner_d    = 1'b0;
          clr_uart_d = 1'b1;
          state_d    = PEND;
        end else if (cmd_rdy_tour) begin
          cmd_d      = cmd_tour;
          cmd_rdy_d  = 1'b1;
          owner_d    = 1'b1;
          clr_tour_d = 1'b1;
          state_d    = PEND;
        end
      end
      PEND: begin
        if (clr_cmd_rdy) begin
          cmd_rdy_d = 1'b0;
          wdog_d    = '0;
          if (send_resp) begin
            resp_d      = done_resp;
            resp_vld_d  = 1'b1;
            srt_d       = owner_q;
            idle_hold_d = 1'b1;
            state_d     = IDLE;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        wdog_d = wdog_inc;
        if (send_resp) begin
          resp_d      = done_resp;
          resp_vld_d  = 1'b1;
          srt_d       = owner_q;
          idle_hold_d = 1'b1;
          state_d     = IDLE;
        end else if (wdog_inc == TMO_CYC) begin
          resp_d      = 8'hEE;
          resp_vld_d  = 1'b1;
          tmo_d       = 1'b1;
          idle_hold_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idle_hold_q <= 1'b0;
      cmd_q       <= '0;
      cmd_rdy_q   <= 1'b0;
      clr_uart_q  <= 1'b0;
      clr_tour_q  <= 1'b0;
      srt_q       <= 1'b0;
      resp_q      <= '0;
      resp_vld_q  <= 1'b0;
      owner_q     <= 1'b0;
      tmo_q       <= 1'b0;
      wdog_q      <= '0;
    end else begin
      state_q     <= state_d;
      idle_hold_q <= idle_hold_d;
      cmd_q       <= cmd_d;
      cmd_rdy_q   <= cmd_rdy_d;
      clr_uart_q  <= clr_uart_d;
      clr_tour_q  <= clr_tour_d;
      srt_q       <= srt_d;
      resp_q      <= resp_d;
      resp_vld_q  <= resp_vld_d;
      owner_q     <= owner_d;
      tmo_q       <= tmo_d;
      wdog_q      <= wdog_d;
    end
  end

  assign cmd            = cmd_q;
  assign cmd_rdy        = cmd_rdy_q;
  assign clr_rdy_UART   = clr_uart_q;
  assign clr_rdy_tour   = clr_tour_q;
  assign send_resp_tour = srt_q;
  assign resp           = resp_q;
  assign resp_vld       = resp_vld_q;
  assign owner_tour     = owner_q;
  assign tmo_err        = tmo_q;

endmodule

// File: tb/tb_cmd_arbiter.sv
// Directed bench for cmd_arbiter: per-cycle vector table plus hand-written
// timeout and reset sequences.
module tb_cmd_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cmd_UART, cmd_tour, cmd;
  logic        cmd_rdy_UART, clr_rdy_UART, cmd_rdy_tour, clr_rdy_tour, tour_last;
  logic        cmd_rdy, clr_cmd_rdy, send_resp, send_resp_tour, resp_vld, owner_tour, tmo_err;
  logic [7:0]  resp;

  int unsigned n_run = 0;
  int unsigned n_fail = 0;

  cmd_arbiter #(.TMO_CYC(24'd64)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .clr_rdy_UART(clr_rdy_UART),
    .cmd_tour(cmd_tour), .cmd_rdy_tour(cmd_rdy_tour), .clr_rdy_tour(clr_rdy_tour),
    .tour_last(tour_last), .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
    .send_resp(send_resp), .send_resp_tour(send_resp_tour), .resp(resp),
    .resp_vld(resp_vld), .owner_tour(owner_tour), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ru;
    logic [15:0] cu;
    logic        rt;
    logic [15:0] ct;
    logic        tl;
    logic        ccr;
    logic        sr;
    logic [30:0] exp;
  } vec_t;

  vec_t vecs[$];

  // {cmd, cmd_rdy, clr_u, clr_t, send_resp_tour, resp_vld, resp, owner, tmo}
  function automatic logic [30:0] ex(logic [15:0] c, logic r, logic clu, logic clt,
                                     logic srt, logic v, logic [7:0] rs, logic own, logic tmo);
    return {c, r, clu, clt, srt, v, rs, own, tmo};
  endfunction

  function automatic logic [30:0] outs();
    return {cmd, cmd_rdy, clr_rdy_UART, clr_rdy_tour, send_resp_tour, resp_vld, resp,
            owner_tour, tmo_err};
  endfunction

  function automatic vec_t mk(logic ru, logic [15:0] cu, logic rt, logic [15:0] ct,
                              logic tl, logic ccr, logic sr, logic [30:0] e);
    vec_t v;
    v.ru = ru; v.cu = cu; v.rt = rt; v.ct = ct; v.tl = tl; v.ccr = ccr; v.sr = sr; v.exp = e;
    return v;
  endfunction

  task automatic check(string name, logic [30:0] act, logic [30:0] req);
    n_run++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic drive(logic ru, logic [15:0] cu, logic rt, logic [15:0] ct,
                       logic tl, logic ccr, logic sr);
    cmd_rdy_UART = ru; cmd_UART = cu; cmd_rdy_tour = rt; cmd_tour = ct;
    tour_last = tl; clr_cmd_rdy = ccr; send_resp = sr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    // UART only
    vecs.push_back(mk(1, 16'h2002, 0, 0, 0, 0, 0, ex(16'h2002, 1, 1, 0, 0, 0, 8'h00, 0, 0)));
    vecs.push_back(mk(0, 16'h2002, 0, 0, 0, 0, 0, ex(16'h2002, 1, 0, 0, 0, 0, 8'h00, 0, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, ex(16'h2002, 0, 0, 0, 0, 0, 8'h00, 0, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, ex(16'h2002, 0, 0, 0, 0, 0, 8'h00, 0, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, ex(16'h2002, 0, 0, 0, 0, 1, 8'hA5, 0, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, ex(16'h2002, 0, 0, 0, 0, 0, 8'hA5, 0, 0)));
    // tour, not last
    vecs.push_back(mk(0, 0, 1, 16'h2BF1, 0, 0, 0, ex(16'h2BF1, 1, 0, 1, 0, 0, 8'hA5, 1, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, ex(16'h2BF1, 0, 0, 0, 0, 0, 8'hA5, 1, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, ex(16'h2BF1, 0, 0, 0, 1, 1, 8'h5A, 1, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, ex(16'h2BF1, 0, 0, 0, 0, 0, 8'h5A, 1, 0)));
    // tour, last move
    vecs.push_back(mk(0, 0, 1, 16'h23F2, 1, 0, 0, ex(16'h23F2, 1, 0, 1, 0, 0, 8'h5A, 1, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, ex(16'h23F2, 0, 0, 0, 0, 0, 8'h5A, 1, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, ex(16'h23F2, 0, 0, 0, 1, 1, 8'hA5, 1, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, ex(16'h23F2, 0, 0, 0, 0, 0, 8'hA5, 1, 0)));
    // both request: UART first, tour held pending and never double-acked
    vecs.push_back(mk(1, 16'h2001, 1, 16'h27F1, 0, 0, 0, ex(16'h2001, 1, 1, 0, 0, 0, 8'hA5, 0, 0)));
    vecs.push_back(mk(0, 0, 1, 16'h27F1, 0, 0, 0, ex(16'h2001, 1, 0, 0, 0, 0, 8'hA5, 0, 0)));
    vecs.push_back(mk(0, 0, 1, 16'h27F1, 0, 1, 0, ex(16'h2001, 0, 0, 0, 0, 0, 8'hA5, 0, 0)));
    vecs.push_back(mk(0, 0, 1, 16'h27F1, 0, 0, 1, ex(16'h2001, 0, 0, 0, 0, 1, 8'hA5, 0, 0)));
    vecs.push_back(mk(0, 0, 1, 16'h27F1, 0, 0, 0, ex(16'h2001, 0, 0, 0, 0, 0, 8'hA5, 0, 0)));
    vecs.push_back(mk(0, 0, 1, 16'h27F1, 0, 0, 0, ex(16'h27F1, 1, 0, 1, 0, 0, 8'hA5, 1, 0)));
    // clr_cmd_rdy and send_resp together in PEND
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, ex(16'h27F1, 0, 0, 0, 1, 1, 8'h5A, 1, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, ex(16'h27F1, 0, 0, 0, 0, 0, 8'h5A, 1, 0)));
    // send_resp / clr_cmd_rdy ignored in IDLE
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, ex(16'h27F1, 0, 0, 0, 0, 0, 8'h5A, 1, 0)));

    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", outs(), ex(16'h0000, 0, 0, 0, 0, 0, 8'h00, 0, 0));
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].ru, vecs[i].cu, vecs[i].rt, vecs[i].ct, vecs[i].tl, vecs[i].ccr, vecs[i].sr);
      step();
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Watchdog expiry on a tour command: exactly 64 BUSY cycles, no send_resp_tour
    drive(0, 0, 1, 16'h2C01, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 1, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0);
    begin
      int unsigned early = 0;
      for (int k = 1; k < 64; k++) begin
        step();
        if (resp_vld || tmo_err) early++;
      end
      check("tmo_no_early_resp", 31'(early), 31'd0);
    end
    step();
    check("tmo_expiry", outs(), ex(16'h2C01, 0, 0, 0, 0, 1, 8'hEE, 1, 1));
    step();
    check("tmo_pulse_end", {29'd0, resp_vld, tmo_err}, 31'd0);

    // send_resp in the cycle the watchdog reaches the limit wins
    drive(1, 16'h2003, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 1, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (63) step();
    drive(0, 0, 0, 0, 0, 0, 1); step();
    check("tmo_race_resp", outs(), ex(16'h2003, 0, 0, 0, 0, 1, 8'hA5, 0, 0));
    drive(0, 0, 0, 0, 0, 0, 0); step();

    // Async reset in BUSY abandons the command, then re-arbitration
    drive(1, 16'h2004, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 1, 0); step();
    drive(1, 16'h2005, 0, 0, 0, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", outs(), ex(16'h0000, 0, 0, 0, 0, 0, 8'h00, 0, 0));
    step();
    check("reset_hold", outs(), ex(16'h0000, 0, 0, 0, 0, 0, 8'h00, 0, 0));
    drive(1, 16'h2005, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step();
    check("regrant_after_reset", outs(), ex(16'h2005, 1, 1, 0, 0, 0, 8'h00, 0, 0));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/cmd_arbiter.md
CMD_ARBITER -- requirements
Module: cmd_arbiter

Interface
REQ-001 The block SHALL have parameter TMO_CYC, default 24'hFF_FFFF, the watchdog limit in clk cycles for the BUSY state (1..2^24-1).
REQ-002 The block SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port cmd_UART  input  16  command from the UART/Bluetooth command receiver.
REQ-005 The block SHALL have port cmd_rdy_UART  input  1  cmd_UART valid; held high until clr_rdy_UART.
REQ-006 The block SHALL have port clr_rdy_UART  output  1  one-cycle acknowledge to the UART source.
REQ-007 The block SHALL have port cmd_tour  input  16  command from the tour command generator.
REQ-008 The block SHALL have port cmd_rdy_tour  input  1  cmd_tour valid; held high until clr_rdy_tour.
REQ-009 The block SHALL have port clr_rdy_tour  output  1  one-cycle acknowledge to the tour source.
REQ-010 The block SHALL have port tour_last  input  1  current tour command is the final move of the tour.
REQ-011 The block SHALL have port cmd  output  16  registered command presented to the command processor.
REQ-012 The block SHALL have port cmd_rdy  output  1  cmd valid to the command processor.
REQ-013 The block SHALL have port clr_cmd_rdy  input  1  command processor has accepted cmd.
REQ-014 The block SHALL have port send_resp  input  1  command processor has finished executing cmd.
REQ-015 The block SHALL have port send_resp_tour  output  1  one-cycle completion pulse to the tour source.
REQ-016 The block SHALL have port resp  output  8  response byte for the UART transmitter.
REQ-017 The block SHALL have port resp_vld  output  1  one-cycle strobe; resp valid.
REQ-018 The block SHALL have port owner_tour  output  1  1 when the current/last grant went to the tour source.
REQ-019 The block SHALL have port tmo_err  output  1  one-cycle pulse on watchdog expiry.

Function
REQ-020 The block SHALL implement FSM states IDLE, PEND, BUSY, all outputs registered.
REQ-021 In IDLE with cmd_rdy_UART high, the block SHALL, at the edge: cmd<=cmd_UART, cmd_rdy<=1, owner_tour<=0, clr_rdy_UART pulsed high for the following cycle, go to PEND.
REQ-022 In IDLE with only cmd_rdy_tour high, the block SHALL do the same using cmd_tour, owner_tour<=1, clr_rdy_tour pulsed.
REQ-023 With both requests high in IDLE, UART SHALL win (strict priority); tour request stays pending untouched.
REQ-024 The block SHALL pulse exactly one clr_rdy_* per grant, never in PEND/BUSY, so a slow-clearing source is never double-granted.
REQ-025 In PEND, on clr_cmd_rdy the block SHALL set cmd_rdy<=0, clear the watchdog, and go to BUSY; cmd SHALL hold its value.
REQ-026 In BUSY, on send_resp the block SHALL for one cycle assert resp_vld, with resp=8'hA5 if owner UART, 8'h5A if owner tour and tour_last=0, 8'hA5 if owner tour and tour_last=1; and go to IDLE.
REQ-027 On that completion, if owner tour the block SHALL also pulse send_resp_tour for the same cycle as resp_vld.
REQ-028 clr_cmd_rdy and send_resp high together in PEND SHALL be a completion: cmd_rdy<=0, response per REQ-026/027, go to IDLE.
REQ-029 In BUSY the 24-bit watchdog SHALL increment each cycle; on reaching TMO_CYC without send_resp, the block SHALL pulse tmo_err, resp=8'hEE with resp_vld, no send_resp_tour, go to IDLE.
REQ-030 send_resp in the same cycle the watchdog reaches TMO_CYC SHALL win: normal response, no tmo_err.
REQ-031 The block SHALL ignore send_resp in IDLE and clr_cmd_rdy in IDLE/BUSY.
REQ-032 After any return to IDLE, the block SHALL wait at least one cycle in IDLE before the next grant.

Reset
REQ-033 On rst_n low, the block SHALL immediately enter IDLE: cmd=16'h0000, cmd_rdy=0, clr_rdy_*=0, send_resp_tour=0, resp=8'h00, resp_vld=0, owner_tour=0, tmo_err=0, watchdog=0.
REQ-034 Reset mid-PEND/BUSY SHALL abandon the command with no response; pending requests are re-arbitrated after release.

Verification
REQ-035 UART only: cmd_UART=16'h2002 -> cmd=16'h2002, cmd_rdy=1 and one clr_rdy_UART pulse next cycle; clr_cmd_rdy, send_resp -> resp=8'hA5, resp_vld one cycle, no send_resp_tour.
REQ-036 Tour only: cmd_tour=16'h2BF1, tour_last=0 -> owner_tour=1; completion gives resp=8'h5A plus send_resp_tour pulse; repeat with 16'h23F2, tour_last=1 -> resp=8'hA5.
REQ-037 Both requests same cycle (UART 16'h2001, tour 16'h27F1) -> UART granted first; after its completion and one idle cycle, cmd=16'h27F1.
REQ-038 TMO_CYC=64, clr_cmd_rdy with no send_resp -> tmo_err and resp=8'hEE after 64 BUSY cycles; send_resp on cycle 64 -> normal response, no tmo_err.
REQ-039 clr_cmd_rdy and send_resp same cycle in PEND -> single completion; assert rst_n low in BUSY -> all outputs at reset values, no resp_vld.
